// File: rtl/apu_cluster_package.sv
// rtl/apu_cluster_package.sv - shared types and constants for the APU cluster
// Purpose: core-ID tag type and limits used by the shared-FU arbiters.
// Ports: none (package).
package apu_cluster_package;

    // Largest core count any APU arbiter in the cluster is built for.
    localparam int C_MAX_APU_CORES = 16;

    // Tag ID field is sized for the largest cluster so one type serves all.
    localparam int C_APU_ID_W = $clog2(C_MAX_APU_CORES);

    typedef struct packed {
        logic                  valid;
        logic [C_APU_ID_W-1:0] id;
    } apu_tag_t;

    // Core-ID width for a given core count, never below one bit.
    function automatic int apu_id_width(input int nb_cores);
        return (nb_cores > 1) ? $clog2(nb_cores) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_apu.sv
// rtl/rr_arbiter_apu.sv - combinational round-robin picker for APU requests
// Purpose: finds the first requester at or after rr_ptr (mod NB_CORES).
// Ports:
//   req    in  NB_CORES  request vector
//   rr_ptr in  CW        highest-priority core this cycle
//   gnt    out NB_CORES  one-hot grant, zero when no request
//   win    out CW        index of the granted core (0 when none)
//   any    out 1         at least one request present
module rr_arbiter_apu #(
    parameter int NB_CORES = 4,
    parameter int CW       = 2
) (
    input  logic [NB_CORES-1:0] req,
    input  logic [CW-1:0]       rr_ptr,
    output logic [NB_CORES-1:0] gnt,
    output logic [CW-1:0]       win,
    output logic                any
);

    int idx;

    always_comb begin
        any = 1'b0;
        win = '0;
        idx = 0;
        // Walk the cores in priority order; the first requester sticks.
        for (int k = 0; k < NB_CORES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NB_CORES) begin
                idx = idx - NB_CORES;
            end
            for (int c = 0; c < NB_CORES; c++) begin
                if (!any && (c == idx) && req[c]) begin
                    any = 1'b1;
                    win = CW'(c);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            gnt[c] = any && (win == CW'(c));
        end
    end

endmodule

// File: rtl/apu_fu_arbiter.sv
// rtl/apu_fu_arbiter.sv - round-robin sharing of one pipelined FP unit among cores
// Purpose: grants one core per cycle, muxes its operands to the unit, tags the
//          grant through a LATENCY-deep pipeline and routes results back.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_i/gnt_o                   per-core request / one-hot grant
//   operands_i, op_i, flags_i     per-core request payload, core c at slice c
//   fu_req_o, fu_operands_o,
//   fu_op_o, fu_flags_o           issue to the shared unit
//   fu_valid_i, fu_result_i,
//   fu_flags_i                    result from the shared unit
//   rvalid_o, result_o, rflags_o  per-core result valid, broadcast result/status
//   err_o                         sticky result/tag misalignment
module apu_fu_arbiter
    import apu_cluster_package::*;
#(
    parameter int NB_CORES = 4,
    parameter int LATENCY  = 1,
    parameter int WIDTH    = 32,
    parameter int WOP      = 1,
    parameter int NARGS    = 3,
    parameter int NDSFLAGS = 3,
    parameter int NUSFLAGS = 5
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NB_CORES-1:0]             req_i,
    output logic [NB_CORES-1:0]             gnt_o,
    input  logic [NB_CORES*NARGS*WIDTH-1:0] operands_i,
    input  logic [NB_CORES*WOP-1:0]         op_i,
    input  logic [NB_CORES*NDSFLAGS-1:0]    flags_i,
    output logic                            fu_req_o,
    output logic [NARGS*WIDTH-1:0]          fu_operands_o,
    output logic [WOP-1:0]                  fu_op_o,
    output logic [NDSFLAGS-1:0]             fu_flags_o,
    input  logic                            fu_valid_i,
    input  logic [WIDTH-1:0]                fu_result_i,
    input  logic [NUSFLAGS-1:0]             fu_flags_i,
    output logic [NB_CORES-1:0]             rvalid_o,
    output logic [WIDTH-1:0]                result_o,
    output logic [NUSFLAGS-1:0]             rflags_o,
    output logic                            err_o
);

    localparam int CW = apu_id_width(NB_CORES);

    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] win;
    logic          any;
    apu_tag_t      tag_q [LATENCY];
    apu_tag_t      tag_out;
    logic          err_q;

    rr_arbiter_apu #(
        .NB_CORES (NB_CORES),
        .CW       (CW)
    ) u_rr (
        .req    (req_i),
        .rr_ptr (rr_ptr),
        .gnt    (gnt_o),
        .win    (win),
        .any    (any)
    );

    assign fu_req_o = any;

    // Winner's payload; zero when idle so the unit sees quiet buses.
    always_comb begin
        fu_operands_o = '0;
        fu_op_o       = '0;
        fu_flags_o    = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            if (any && (win == CW'(c))) begin
                fu_operands_o = operands_i[c*NARGS*WIDTH +: NARGS*WIDTH];
                fu_op_o       = op_i[c*WOP +: WOP];
                fu_flags_o    = flags_i[c*NDSFLAGS +: NDSFLAGS];
            end
        end
    end

    assign tag_out = tag_q[LATENCY-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            rr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            tag_q[0] <= '{valid: any, id: C_APU_ID_W'(win)};
            for (int k = 1; k < LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            // Next search starts just past the winner; the compare also pins
            // the pointer to 0 for a single-core build.
            if (any) begin
                rr_ptr <= (win == CW'(NB_CORES - 1)) ? '0 : win + CW'(1);
            end
            if (fu_valid_i != tag_out.valid) begin
                err_q <= 1'b1;
            end
        end
    end

    // A result only reaches a core when a tracked tag lines up with it.
    always_comb begin
        rvalid_o = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            rvalid_o[c] = fu_valid_i & tag_out.valid & (tag_out.id == C_APU_ID_W'(c));
        end
    end

    assign result_o = fu_result_i;
    assign rflags_o = fu_flags_i;
    assign err_o    = err_q;

endmodule

// File: tb/tb_apu_fu_arbiter.sv
// tb/tb_apu_fu_arbiter.sv - scoreboard bench for apu_fu_arbiter with a fake pipelined unit
module tb_apu_fu_arbiter;

    localparam int NB   = 4;
    localparam int LAT  = 2;
    localparam int W    = 32;
    localparam int WOP  = 2;
    localparam int NA   = 3;
    localparam int NDS  = 3;
    localparam int NUS  = 5;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [NB-1:0]         req_i;
    logic [NB-1:0]         gnt_o;
    logic [NB*NA*W-1:0]    operands_i;
    logic [NB*WOP-1:0]     op_i;
    logic [NB*NDS-1:0]     flags_i;
    logic                  fu_req_o;
    logic [NA*W-1:0]       fu_operands_o;
    logic [WOP-1:0]        fu_op_o;
    logic [NDS-1:0]        fu_flags_o;
    logic                  fu_valid_i;
    logic [W-1:0]          fu_result_i;
    logic [NUS-1:0]        fu_flags_i;
    logic [NB-1:0]         rvalid_o;
    logic [W-1:0]          result_o;
    logic [NUS-1:0]        rflags_o;
    logic                  err_o;

    always #5 clk = ~clk;

    apu_fu_arbiter #(
        .NB_CORES (NB), .LATENCY (LAT), .WIDTH (W), .WOP (WOP),
        .NARGS (NA), .NDSFLAGS (NDS), .NUSFLAGS (NUS)
    ) dut (
        .clk_i (clk), .rst_ni (rst_ni), .req_i (req_i), .gnt_o (gnt_o),
        .operands_i (operands_i), .op_i (op_i), .flags_i (flags_i),
        .fu_req_o (fu_req_o), .fu_operands_o (fu_operands_o), .fu_op_o (fu_op_o),
        .fu_flags_o (fu_flags_o), .fu_valid_i (fu_valid_i), .fu_result_i (fu_result_i),
        .fu_flags_i (fu_flags_i), .rvalid_o (rvalid_o), .result_o (result_o),
        .rflags_o (rflags_o), .err_o (err_o)
    );

    typedef struct {
        int             core;
        logic [W-1:0]   res;
        logic [NUS-1:0] fl;
        int             due;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;
    int                m_ptr = 0;
    bit                mon_en = 0;
    logic [NB-1:0]     exp_gnt = '0;
    logic [NA*W-1:0]   exp_ops;
    logic [WOP-1:0]    exp_op;
    logic [NDS-1:0]    exp_fl;
    bit                exp_err = 0;
    bit                err_next = 0;
    bit                inject_pending = 0;
    bit                inject_active = 0;
    logic [NA*W-1:0]   c_ops [NB];
    logic [WOP-1:0]    c_op  [NB];
    logic [NDS-1:0]    c_fl  [NB];
    bit                pv [LAT];
    logic [NUS+W-1:0]  pd [LAT];
    bit                cap_v;
    logic [NUS+W-1:0]  cap_d;

    // Stand-in for the FP unit: 3.0 + 1.0 gives 4.0, anything else is a hash.
    function automatic logic [NUS+W-1:0] unit_model(input logic [NA*W-1:0] ops,
                                                    input logic [WOP-1:0] op,
                                                    input logic [NDS-1:0] fl);
        logic [W-1:0]   r;
        logic [NUS-1:0] s;
        if (ops[W-1:0] == 32'h40400000 && ops[2*W-1:W] == 32'h3f800000) begin
            r = 32'h40800000;
            s = '0;
        end else begin
            r = (ops[W-1:0] + ops[2*W-1:W]) ^ ops[3*W-1:2*W] ^ {27'd0, op, fl};
            s = r[NUS-1:0] ^ {op, fl};
        end
        return {s, r};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: the fake unit samples the issue bus, then advances its pipe.
    task automatic tick();
        @(negedge clk);
        #2;
        cap_v    = fu_req_o;
        cap_d    = unit_model(fu_operands_o, fu_op_o, fu_flags_o);
        err_next = inject_active;
        @(posedge clk);
        #1;
        cyc++;
        exp_err = exp_err | err_next;
        for (int k = LAT - 1; k > 0; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
        end
        pv[0] = cap_v;
        pd[0] = cap_d;
        inject_active  = inject_pending;
        inject_pending = 0;
        fu_valid_i = pv[LAT-1] | inject_active;
        {fu_flags_i, fu_result_i} = pd[LAT-1];
    endtask

    task automatic issue(input logic [NB-1:0] r, input bit rnd);
        int win;
        if (rnd) begin
            for (int c = 0; c < NB; c++) begin
                c_ops[c] = {$urandom, $urandom, $urandom};
                c_op[c]  = WOP'($urandom);
                c_fl[c]  = NDS'($urandom);
            end
        end
        for (int c = 0; c < NB; c++) begin
            operands_i[c*NA*W +: NA*W] = c_ops[c];
            op_i[c*WOP +: WOP]         = c_op[c];
            flags_i[c*NDS +: NDS]      = c_fl[c];
        end
        req_i = r;
        win = -1;
        for (int k = 0; k < NB; k++) begin
            if (win < 0 && r[(m_ptr + k) % NB]) win = (m_ptr + k) % NB;
        end
        exp_gnt = '0;
        if (win >= 0) begin
            logic [NUS+W-1:0] u;
            exp_gnt[win] = 1'b1;
            exp_ops = c_ops[win];
            exp_op  = c_op[win];
            exp_fl  = c_fl[win];
            u = unit_model(c_ops[win], c_op[win], c_fl[win]);
            sb.push_back('{core: win, res: u[W-1:0], fl: u[NUS+W-1:W], due: cyc + LAT});
            m_ptr = (win + 1) % NB;
        end
        tick();
    endtask

    task automatic do_reset(input int n);
        rst_ni = 1'b0;
        req_i = '0;
        sb.delete();
        for (int k = 0; k < LAT; k++) begin
            pv[k] = 0;
            pd[k] = '0;
        end
        fu_valid_i = 1'b0;
        inject_pending = 0;
        inject_active = 0;
        err_next = 0;
        exp_err = 0;
        m_ptr = 0;
        exp_gnt = '0;
        repeat (n) tick();
        rst_ni = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [NB-1:0] oh;
            chk("gnt", gnt_o, exp_gnt);
            chk("fu_req", fu_req_o, exp_gnt != '0);
            if (exp_gnt != '0) chk("fu_payload", {fu_operands_o, fu_op_o, fu_flags_o}, {exp_ops, exp_op, exp_fl});
            chk("err", err_o, exp_err);
            if (rvalid_o !== '0) begin
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", rvalid_o, '0);
                end else begin
                    mon_e = sb.pop_front();
                    oh = '0;
                    oh[mon_e.core] = 1'b1;
                    chk("rvalid_id", rvalid_o, oh);
                    chk("rvalid_time", cyc, mon_e.due);
                    chk("result", result_o, mon_e.res);
                    chk("rflags", rflags_o, mon_e.fl);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                oh = '0;
                oh[sb[0].core] = 1'b1;
                chk("rvalid_missing", rvalid_o, oh);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        req_i = '0;
        operands_i = '0;
        op_i = '0;
        flags_i = '0;
        fu_valid_i = 1'b0;
        fu_result_i = '0;
        fu_flags_i = '0;
        for (int c = 0; c < NB; c++) begin
            c_ops[c] = '0;
            c_op[c] = '0;
            c_fl[c] = '0;
        end
        mon_en = 1;
        do_reset(3);

        // Single request from core 2: 3.0 + 1.0.
        c_ops[2] = {32'h00000000, 32'h3f800000, 32'h40400000};
        c_op[2] = 2'd1;
        c_fl[2] = 3'd0;
        issue(4'b0100, 0);
        repeat (LAT + 1) issue('0, 0);

        // All cores continuously from reset: 0,1,2,3,0,...
        do_reset(2);
        repeat (12) issue(4'hF, 1);
        repeat (LAT + 1) issue('0, 0);

        // Cores 1 and 3 in alternate cycles.
        repeat (8) begin
            issue(4'b0010, 1);
            issue(4'b1000, 1);
        end
        repeat (LAT + 1) issue('0, 0);

        // Core 0 held, core 3 pulsing.
        for (int i = 0; i < 16; i++) issue({(i % 3) == 1, 3'b001}, 1);
        repeat (LAT + 1) issue('0, 0);

        // Stray unit result with nothing in flight; error must stick.
        inject_pending = 1;
        issue('0, 0);
        repeat (5) issue('0, 0);
        do_reset(2);
        issue('0, 0);

        // Reset with two ops in flight, pointer left at 3.
        issue(4'b0010, 1);
        issue(4'b0100, 1);
        do_reset(2);
        issue(4'b1001, 1);
        repeat (LAT + 1) issue('0, 0);

        // Random traffic.
        repeat (400) issue(NB'($urandom_range(0, 15) & $urandom_range(0, 15)), 1);
        repeat (LAT + 2) issue('0, 0);

        chk("sb_drained", sb.size(), 0);
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
